fp16_divider_iter: RTL and testbench

- Iterative IEEE-754 binary16 divider (out = a / b), the inverse-operation companion to the pipelined fp16 multiplier in the same arithmetic datapath.
- Trades throughput for area: one restoring-division quotient bit per cycle, fixed latency.
- Uses valid/ready handshakes on input and output so it can sit between stream stages.
- Special-value encodings match the multiplier: canonical NaN 16'h7e00, infinity {sign,15'h7c00}.

---
 rtl/fp16_divider_iter.sv | 220 ++++++++++++++++++++++
 tb/tb_fp16_divider_iter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_divider_iter.sv
// Iterative binary16 divider, one restoring quotient bit per cycle.
// Fixed 15-edge latency from accept to out_valid, valid/ready on both sides.
module fp16_divider_iter #(
  parameter int QBITS = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_DIV, S_RND, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE, SP_NAN, SP_INF, SP_ZERO
  } spec_t;

  state_t state, state_n;
  logic armed;
  logic [15:0] a_q, b_q;
  logic sign;
  logic signed [7:0] ex;
  logic [10:0] mb;
  logic [11:0] r;
  logic [QBITS-1:0] q;
  logic [3:0] cnt;
  spec_t spec;
  logic [15:0] out_q;
  logic ov;

  assign in_ready  = armed & (state == S_IDLE);
  assign out       = out_q;
  assign out_valid = ov;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i < 11; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  logic [4:0] ea, eb;
  logic [9:0] fa, fb;
  logic [10:0] siga, sigb, ma_n, mb_n;
  logic [3:0] lza, lzb;
  logic signed [7:0] eea, eeb, e_n;
  logic a_nan, b_nan, a_inf, b_inf;
  logic a_zero, b_zero;
  spec_t spec_n;

  // unpack, normalise subnormals, classify specials
  always_comb begin
    ea = a_q[14:10];
    eb = b_q[14:10];
    fa = a_q[9:0];
    fb = b_q[9:0];
    siga = {|ea, fa};
    sigb = {|eb, fb};
    lza = lzc11(siga);
    lzb = lzc11(sigb);
    ma_n = siga << lza;
    mb_n = sigb << lzb;
    eea = (|ea) ? $signed({3'b0, ea})
                : 8'sd1 - $signed({4'b0, lza});
    eeb = (|eb) ? $signed({3'b0, eb})
                : 8'sd1 - $signed({4'b0, lzb});
    e_n = eea - eeb + 8'sd15;
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);
    a_zero = ~(|a_q[14:0]);
    b_zero = ~(|b_q[14:0]);
    spec_n = SP_NONE;
    if (a_nan | b_nan | (a_zero & b_zero)
        | (a_inf & b_inf))
      spec_n = SP_NAN;
    else if (a_inf | b_zero)
      spec_n = SP_INF;
    else if (a_zero | b_inf)
      spec_n = SP_ZERO;
  end

  logic ge;
  logic [11:0] r_sub;

  // one restoring subtract step
  always_comb begin
    ge = (r >= {1'b0, mb});
    r_sub = ge ? r - {1'b0, mb} : r;
  end

  logic [12:0] qn;
  logic signed [7:0] en, e2, e3, diff;
  logic [10:0] sig, sig2, m3;
  logic g, st, g2, st2, inc;
  logic [3:0] sh;
  logic [23:0] ext;
  logic [11:0] mant;
  logic [15:0] res;
  logic unused_ok;

  // normalise quotient, denormalise, round to nearest even, pack
  always_comb begin
    qn = q[12] ? q : {q[11:0], 1'b0};
    en = q[12] ? ex : ex - 8'sd1;
    sig = qn[12:2];
    g = qn[1];
    st = qn[0] | (|r);
    diff = 8'sd1 - en;
    sh = 4'd0;
    ext = '0;
    sig2 = sig;
    g2 = g;
    st2 = st;
    e2 = en;
    if (en <= 8'sd0) begin
      sh = (diff > 8'sd12) ? 4'd12 : diff[3:0];
      ext = {sig, g, 12'b0} >> sh;
      sig2 = ext[23:13];
      g2 = ext[12];
      st2 = st | (|ext[11:0]);
      e2 = 8'sd0;
    end
    inc = g2 & (st2 | sig2[0]);
    mant = {1'b0, sig2} + {11'b0, inc};
    if (mant[11]) begin
      m3 = mant[11:1];
      e3 = e2 + 8'sd1;
    end else begin
      m3 = mant[10:0];
      e3 = (e2 == 8'sd0 && mant[10]) ? 8'sd1 : e2;
    end
    unique case (spec)
      SP_NAN:  res = 16'h7e00;
      SP_INF:  res = {sign, 15'h7c00};
      SP_ZERO: res = {sign, 15'h0000};
      default:
        res = (e3 >= 8'sd31) ? {sign, 15'h7c00}
                             : {sign, e3[4:0], m3[9:0]};
    endcase
    unused_ok = ^{m3[10], e3[7:5], diff[7:4], r_sub[11]};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (in_valid & in_ready) state_n = S_NORM;
      S_NORM: state_n = S_DIV;
      S_DIV:  if (cnt == 4'd0) state_n = S_RND;
      S_RND:  state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sign <= 1'b0;
      ex <= '0;
      mb <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      spec <= SP_NONE;
      out_q <= '0;
      ov <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid & in_ready) begin
          a_q <= a;
          b_q <= b;
        end
        S_NORM: begin
          sign <= a_q[15] ^ b_q[15];
          ex <= e_n;
          mb <= mb_n;
          r <= {1'b0, ma_n};
          q <= '0;
          cnt <= 4'(QBITS - 1);
          spec <= spec_n;
        end
        S_DIV: begin
          q <= {q[QBITS-2:0], ge};
          r <= {r_sub[10:0], 1'b0};
          cnt <= cnt - 4'd1;
        end
        S_RND: begin
          out_q <= res;
          ov <= 1'b1;
        end
        S_DONE: if (out_ready) ov <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider_iter.sv
// Bench for fp16_divider_iter: real-arithmetic reference model,
// directed vectors, backpressure and mid-operation reset.
module tb_fp16_divider_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic in_ready, out_valid;
  logic [15:0] out;

  fp16_divider_iter dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int acc_q[$];
  bit prev_v = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  function automatic real p2(input int n);
    real v = 1.0;
    if (n >= 0) repeat (n) v = v * 2.0;
    else repeat (-n) v = v / 2.0;
    return v;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    int ex = int'(h[14:10]);
    int fr = int'(h[9:0]);
    if (ex == 0) return $itor(fr) * p2(-24);
    return $itor(fr + 1024) * p2(ex - 25);
  endfunction

  // round a positive real to binary16, nearest-even
  function automatic logic [15:0] r2f(input real x,
                                      input logic s);
    int e = 0;
    int n;
    real sc, fr;
    if (x == 0.0) return {s, 15'h0000};
    while (x >= p2(e + 1) && e < 80) e++;
    while (x < p2(e) && e > -80) e--;
    if (e < -14) e = -14;
    sc = x / p2(e - 10);
    n = $rtoi(sc);
    fr = sc - $itor(n);
    if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    if (e + 15 >= 31) return {s, 15'h7c00};
    if (n >= 1024) return {s, 5'(e + 15), 10'(n - 1024)};
    return {s, 5'd0, 10'(n)};
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [15:0] y);
    logic s = x[15] ^ y[15];
    logic xn = (x[14:10] == 5'h1f) && (x[9:0] != 0);
    logic yn = (y[14:10] == 5'h1f) && (y[9:0] != 0);
    logic xi = (x[14:0] == 15'h7c00);
    logic yi = (y[14:0] == 15'h7c00);
    logic xz = (x[14:0] == 15'h0);
    logic yz = (y[14:0] == 15'h0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 16'h7e00;
    if (xi || yz) return {s, 15'h7c00};
    if (xz || yi) return {s, 15'h0000};
    return r2f(f2r(x) / f2r(y), s);
  endfunction

  // compare process: every cycle out_valid is high
  always @(negedge clk) begin
    #1;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0)
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        else begin
          chk("out", 32'(out), 32'(exp_q[0]));
          if (!prev_v)
            chk("latency", 32'(cyc), 32'(acc_q[0] + 16));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [15:0] xa,
                      input logic [15:0] xb,
                      input logic [15:0] ev);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    exp_q.push_back(ev);
    acc_q.push_back(cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    acc_q.delete();
  endtask

  localparam int NV = 18;
  logic [15:0] va [NV] = '{
    16'h4000, 16'h3c00, 16'hc500, 16'h0000, 16'h7c00,
    16'h7e01, 16'hbc00, 16'h3c00, 16'h8000, 16'h7bff,
    16'h0400, 16'h0001, 16'h0001, 16'h0003, 16'h7c00,
    16'h3c00, 16'h4000, 16'h3c00};
  logic [15:0] vb [NV] = '{
    16'h3c00, 16'h4200, 16'h4000, 16'h0000, 16'h7c00,
    16'h3c00, 16'h0000, 16'h7c00, 16'h3c00, 16'h0001,
    16'h4000, 16'h4000, 16'h0001, 16'h4000, 16'h3c00,
    16'h0000, 16'h0400, 16'h3c01};
  logic [15:0] ve [NV] = '{
    16'h4000, 16'h3555, 16'hc100, 16'h7e00, 16'h7e00,
    16'h7e00, 16'hfc00, 16'h0000, 16'h8000, 16'h7c00,
    16'h0200, 16'h0000, 16'h3c00, 16'h0002, 16'h7c00,
    16'h7c00, 16'h7800, 16'h3bfe};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] x, y;
    int n;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++)
      chk("model_pin", 32'(model(va[i], vb[i])), 32'(ve[i]));

    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], ve[i]);
      wait_done();
      if (i == 0)
        chk("ready_after_hs", 32'(in_ready), 32'd1);
    end

    for (int i = 0; i < 12; i++) begin
      x = 16'($urandom_range(0, 65535));
      y = 16'($urandom_range(0, 65535));
      send(x, y, model(x, y));
      wait_done();
    end

    out_ready = 1'b0;
    send(16'h4400, 16'h4000, 16'h4000);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      a = 16'h3c00;
      b = 16'h4000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_idle", 32'(in_ready), 32'd1);
    send(16'h4600, 16'h4000, 16'h4200);
    wait_done();

    send(16'h4200, 16'h3c00, 16'h4200);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(in_ready), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_out", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
